// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and constant-multiply helper
package vga_pkg;

   localparam int CLK_DIV_DEF = 4;
   localparam int H_VIS       = 640;
   localparam int H_FP        = 16;
   localparam int H_SYNC      = 96;
   localparam int H_BP        = 48;
   localparam int V_VIS       = 480;
   localparam int V_FP        = 10;
   localparam int V_SYNC      = 2;
   localparam int V_BP        = 33;
   localparam int H_TOTAL     = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL     = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int SCALE_DEF   = 2;
   localparam int BG_W        = H_VIS >> SCALE_DEF;
   localparam int BG_H        = V_VIS >> SCALE_DEF;
   localparam int AW_DEF      = 15;

   // Shift-and-add multiply by a constant; for k=160 this reduces to (y<<7)+(y<<5).
   function automatic logic [19:0] mul_const(input logic [9:0] y, input int k);
      logic [19:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++) begin
         if (k[i]) acc = acc + (20'(y) << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/vga_tick_div.sv
// rtl/vga_tick_div.sv - system clock divider producing a one-clk pixel tick
module vga_tick_div #(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_pix_tick
);

   localparam int              LP_DW   = $clog2(CLK_DIV);
   localparam logic [LP_DW-1:0] LP_LAST = LP_DW'(CLK_DIV - 1);

   logic [LP_DW-1:0] r_div;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div <= '0;
      end else if (r_div == LP_LAST) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   assign o_pix_tick = (r_div == LP_LAST);

endmodule

// File: rtl/vga_scan.sv
// rtl/vga_scan.sv - VGA scan counters, background address and lookup-aligned sync/blank
module vga_scan
   import vga_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF,
   parameter int H_VIS   = vga_pkg::H_VIS,
   parameter int H_FP    = vga_pkg::H_FP,
   parameter int H_SYNC  = vga_pkg::H_SYNC,
   parameter int H_BP    = vga_pkg::H_BP,
   parameter int V_VIS   = vga_pkg::V_VIS,
   parameter int V_FP    = vga_pkg::V_FP,
   parameter int V_SYNC  = vga_pkg::V_SYNC,
   parameter int V_BP    = vga_pkg::V_BP,
   parameter int SCALE   = SCALE_DEF,
   parameter int AW      = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   output logic          pix_tick,
   output logic [9:0]    px,
   output logic [9:0]    py,
   output logic [AW-1:0] ad,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic          frame_start
);

   localparam logic [9:0] LP_H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] LP_V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] LP_H_VIS  = 10'(H_VIS);
   localparam logic [9:0] LP_V_VIS  = 10'(V_VIS);
   localparam logic [9:0] LP_HS_BEG = 10'(H_VIS + H_FP);
   localparam logic [9:0] LP_HS_END = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] LP_VS_BEG = 10'(V_VIS + V_FP);
   localparam logic [9:0] LP_VS_END = 10'(V_VIS + V_FP + V_SYNC);
   localparam int         LP_BG_W   = H_VIS >> SCALE;

   logic          w_tick;
   logic          w_video_raw;
   logic          w_hs_raw;
   logic          w_vs_raw;
   logic [AW-1:0] w_addr;

   logic [9:0]    r_px;
   logic [9:0]    r_py;
   logic [AW-1:0] r_ad;
   logic [1:0]    r_hs_d;
   logic [1:0]    r_vs_d;
   logic [1:0]    r_vo_d;
   logic          r_frame_start;

   vga_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
      .i_clk      (clk),
      .i_rst      (rst),
      .o_pix_tick (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_px <= '0;
         r_py <= '0;
      end else if (w_tick) begin
         if (r_px == LP_H_LAST) begin
            r_px <= '0;
            r_py <= (r_py == LP_V_LAST) ? '0 : r_py + 1'b1;
         end else begin
            r_px <= r_px + 1'b1;
         end
      end
   end

   always_comb begin
      w_video_raw = (r_px < LP_H_VIS) && (r_py < LP_V_VIS);
      w_hs_raw    = !((r_px >= LP_HS_BEG) && (r_px < LP_HS_END));
      w_vs_raw    = !((r_py >= LP_VS_BEG) && (r_py < LP_VS_END));
      w_addr      = AW'(mul_const(r_py >> SCALE, LP_BG_W) + 20'(r_px >> SCALE));
   end

   // ad is one stage, the lookup adds another; sync/blank ride a two-stage pipe to match.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ad          <= '0;
         r_hs_d        <= 2'b11;
         r_vs_d        <= 2'b11;
         r_vo_d        <= 2'b00;
         r_frame_start <= 1'b0;
      end else begin
         r_ad          <= w_video_raw ? w_addr : '0;
         r_hs_d        <= {r_hs_d[0], w_hs_raw};
         r_vs_d        <= {r_vs_d[0], w_vs_raw};
         r_vo_d        <= {r_vo_d[0], w_video_raw};
         r_frame_start <= w_tick && (r_px == LP_H_LAST) && (r_py == LP_V_LAST);
      end
   end

   assign pix_tick    = w_tick;
   assign px          = r_px;
   assign py          = r_py;
   assign ad          = r_ad;
   assign hsync       = r_hs_d[1];
   assign vsync       = r_vs_d[1];
   assign video_on    = r_vo_d[1];
   assign frame_start = r_frame_start;

endmodule
